lab1_sweep_ctrl: RTL and testbench
==================================

// Module: lab1_sweep_ctrl
// PURPOSE
//  Sequencer for the Lab1 4-input function block F(A,B,C,D). On start it
//  drives all 16 input vectors in order 0..15 (A = MSB, D = LSB). Each vector
//  is held for a programmable number of cycles. F is sampled once per vector
//  into a 16-bit truth table, which is compared against an expected table.
//  Sits between the bench/top level and the function block; replaces
//  hand-timed stimulus with a clocked, self-checking sweep.
// PARAMETERS
//  HOLD_W  8  width of the hold_len input and the internal settle counter
// PORTS
//  clk            in   1       rising-edge clock
//  rst_n          in   1       asynchronous active-low reset
//  start          in   1       begin sweep; honoured only in IDLE
//  abort          in   1       stop sweep; return to IDLE, no done pulse
//  hold_len       in   HOLD_W  settle cycles per vector; 0 is treated as 1
//  exp_tt         in   16      expected F; bit i = F for vector i
//  f_in           in   1       F output of the function block under control
//  A,B,C,D        out  1 each  function block inputs; {A,B,C,D} = vector idx
//  busy           out  1       high from the cycle after start until the sweep ends
//  done           out  1       one-cycle pulse when the sweep completes
//  pass           out  1       tt == exp_tt and sweep completed; held until next start
//  tt             out  16      captured truth table
//  err_cnt        out  5       number of mismatching vectors, 0..16
//  first_err_vld  out  1       at least one mismatch seen this sweep
//  first_err_idx  out  4       index of the lowest mismatching vector
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0, FSM=IDLE, idx=0, cnt=0.
//  FSM states: IDLE, APPLY, SAMPLE, DONE.
//  IDLE: {A,B,C,D}=0, busy=0.
//   - start=1: latch H=max(hold_len,1) and exp_tt.
//   - Clear tt, err_cnt, first_err_*, pass; set idx=0, cnt=0; go to APPLY.
//  APPLY: {A,B,C,D}=idx, busy=1; cnt+1 each cycle; when cnt==H-1, go to SAMPLE.
//  SAMPLE (1 cycle): {A,B,C,D} still idx.
//   - Capture tt[idx]<=f_in.
//   - If f_in != exp[idx]: err_cnt+1; if !first_err_vld, set first_err_idx=idx
//     and first_err_vld=1.
//   - idx==15: go to DONE. Otherwise idx+1, cnt=0, go to APPLY.
//  DONE (1 cycle): done=1, busy=0, {A,B,C,D}=0.
//   - pass=(err_cnt==0), computed including the final SAMPLE update.
//   - Go to IDLE.
//  Timing: each vector is driven for exactly H+1 cycles, and f_in is sampled
//   on its last edge. The sweep takes 16*(H+1) cycles after start; done
//   follows one cycle later.
//  start while busy or in DONE: ignored; latched H and exp are unchanged.
//  abort in APPLY/SAMPLE: next state IDLE, vectors=0, busy=0, pass=0, no done.
//   tt/err_cnt keep partial values. abort has priority over SAMPLE capture.
//   abort with start in IDLE: abort wins; the sweep does not start.
//  hold_len/exp_tt changes mid-sweep: no effect until the next start.
//  err_cnt saturates naturally at 16 (5 bits); no wrap is possible.
//  Async reset mid-sweep: outputs drop to 0 immediately; no done pulse.
//  All outputs registered; no combinational path from f_in to any output.
// TESTING
//  1. XOR model (F=A^B^C^D), exp_tt=16'h6996, hold_len=2, start pulse ->
//     done 48 cycles after start, tt=16'h6996, pass=1, err_cnt=0,
//     first_err_vld=0.
//  2. Same model, exp_tt=16'h6997 -> pass=0, err_cnt=1, first_err_vld=1,
//     first_err_idx=0.
//  3. Same model, exp_tt=16'h9669, hold_len=0 -> each vector held 2 cycles,
//     done at cycle 32, err_cnt=16, first_err_idx=0.
//  4. start pulsed again at idx=7 -> ignored, sweep completes normally.
//     abort at idx=5 -> busy=0 next cycle, no done, pass=0, A..D=0.
//  5. rst_n low during APPLY of idx=9 -> all outputs 0 immediately. Release
//     reset, start again -> clean full sweep matching test 1.
//  6. Check {A,B,C,D} sequence 0..15 in order, each value stable for exactly
//     hold_len+1 cycles (hold_len=3 -> 4 cycles per vector).

Source files
------------

// File: rtl/lab1_sweep_if.sv
// lab1_sweep_if: control/status bundle between a sweep driver and lab1_sweep_ctrl.
//   start, abort, hold_len, exp_tt, f_in  : driver -> controller
//   A..D, busy, done, pass, tt, err_cnt,
//   first_err_vld, first_err_idx          : controller -> driver
interface lab1_sweep_if #(parameter int HOLD_W = 8);
  logic              start;
  logic              abort;
  logic [HOLD_W-1:0] hold_len;
  logic [15:0]       exp_tt;
  logic              f_in;
  logic              A, B, C, D;
  logic              busy;
  logic              done;
  logic              pass;
  logic [15:0]       tt;
  logic [4:0]        err_cnt;
  logic              first_err_vld;
  logic [3:0]        first_err_idx;
  modport master (
    output start, abort, hold_len, exp_tt, f_in,
    input  A, B, C, D, busy, done, pass, tt, err_cnt, first_err_vld, first_err_idx
  );
  modport slave (
    input  start, abort, hold_len, exp_tt, f_in,
    output A, B, C, D, busy, done, pass, tt, err_cnt, first_err_vld, first_err_idx
  );
endinterface

// File: rtl/lab1_sweep_ctrl.sv
// lab1_sweep_ctrl: sweeps vectors 0..15 into F(A,B,C,D), captures its truth table and checks it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of lab1_sweep_if (start/abort/hold_len/exp_tt/f_in in,
//                vector, busy/done/pass and truth-table results out)
module lab1_sweep_ctrl #(
  parameter int HOLD_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  lab1_sweep_if.slave bus
);
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  state_t            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d, h_q, h_d;
  logic [15:0]       exp_q, exp_d, tt_q, tt_d;
  logic [4:0]        err_q, err_d;
  logic              fev_q, fev_d;
  logic [3:0]        fei_q, fei_d;
  logic              pass_q, pass_d;
  logic [3:0]        vec_q, vec_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              run_d;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (bus.start && !bus.abort) begin
        state_d = APPLY;
        h_d     = (bus.hold_len == '0) ? HOLD_W'(1) : bus.hold_len;
        exp_d   = bus.exp_tt;
        tt_d    = '0;
        err_d   = '0;
        fev_d   = 1'b0;
        fei_d   = '0;
        pass_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end
      APPLY: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = bus.abort ? IDLE : (cnt_q == h_q - 1'b1) ? SAMPLE : APPLY;
      end
      SAMPLE: if (bus.abort) state_d = IDLE;
      else begin
        tt_d[idx_q] = bus.f_in;
        if (bus.f_in != exp_q[idx_q]) begin
          err_d = err_q + 1'b1;
          fev_d = 1'b1;
          fei_d = fev_q ? fei_q : idx_q;
        end
        if (idx_q == 4'd15) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          state_d = APPLY;
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from next-state values so they line up with the state register.
    run_d  = (state_d == APPLY) || (state_d == SAMPLE);
    vec_d  = run_d ? idx_d : 4'd0;
    busy_d = run_d;
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      h_q     <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      pass_q  <= 1'b0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      pass_q  <= pass_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign {bus.A, bus.B, bus.C, bus.D} = vec_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.tt            = tt_q;
  assign bus.err_cnt       = err_q;
  assign bus.first_err_vld = fev_q;
  assign bus.first_err_idx = fei_q;
endmodule

// File: tb/tb_lab1_sweep_ctrl.sv
// tb_lab1_sweep_ctrl: randomized self-checking bench for lab1_sweep_ctrl against a truth-table model.
module tb_lab1_sweep_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  lab1_sweep_if #(.HOLD_W(8)) bus ();
  lab1_sweep_ctrl #(.HOLD_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [15:0] ftab;
  logic [3:0]  vec;
  logic [26:0] res;
  assign bus.f_in = ftab[vec];
  assign vec = {bus.A, bus.B, bus.C, bus.D};
  assign res = {bus.tt, bus.err_cnt, bus.first_err_vld, bus.first_err_idx, bus.pass};
  int tests = 0;
  int fails = 0;
  int done_k, vec_bad, busy_bad, done_cnt;

  // Expected {tt, err_cnt, first_err_vld, first_err_idx, pass} for a function table vs expected table.
  function automatic logic [26:0] model(input logic [15:0] ft, input logic [15:0] ex);
    logic [15:0] d;
    logic [3:0]  fi;
    d  = ft ^ ex;
    fi = 4'd0;
    for (int i = 15; i >= 0; i--) if (d[i]) fi = 4'(i);
    return {ft, 5'($countones(d)), d != 16'd0, fi, d == 16'd0};
  endfunction

  task automatic start_sweep(input logic [15:0] ft, input logic [15:0] ex, input logic [7:0] hl);
    @(negedge clk);
    ftab = ft;
    bus.hold_len = hl;
    bus.exp_tt = ex;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hold_len = 8'($urandom);
    bus.exp_tt = 16'($urandom);
  endtask

  // Runs one sweep and records what it saw; k counts cycles after the start edge.
  task automatic run_sweep(input logic [15:0] ft, input logic [15:0] ex, input logic [7:0] hl, input int restart_k);
    int per, total;
    per = ((hl == 8'd0) ? 1 : int'(hl)) + 1;
    total = 16 * per;
    start_sweep(ft, ex, hl);
    done_k = -1;
    vec_bad = 0;
    busy_bad = 0;
    done_cnt = 0;
    for (int k = 0; k <= total + 3; k++) begin
      @(negedge clk);
      if (vec !== (k < total ? 4'(k / per) : 4'd0)) vec_bad++;
      if (bus.busy !== (k < total)) busy_bad++;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (k == restart_k) begin
        bus.start = 1'b1;
        bus.hold_len = hl + 8'd3;
        bus.exp_tt = ~ex;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests++;
    if ({vec, bus.busy, bus.done, res} !== 33'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %0h want 0", {vec, bus.busy, bus.done, res});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_xor_pass;
    run_sweep(16'h6996, 16'h6996, 8'd2, -1);
    tests++;
    if (done_k !== 48) begin fails++; $display("FAIL xor_done_cycle: got %0d want 48", done_k); end
    tests++;
    if (done_cnt !== 1) begin fails++; $display("FAIL xor_done_pulses: got %0d want 1", done_cnt); end
    tests++;
    if (vec_bad + busy_bad !== 0) begin fails++; $display("FAIL xor_vec_busy: got %0d/%0d bad cycles want 0", vec_bad, busy_bad); end
    tests++;
    if (res !== model(16'h6996, 16'h6996) || res[0] !== 1'b1) begin
      fails++; $display("FAIL xor_result: got %0h want %0h", res, model(16'h6996, 16'h6996));
    end
  endtask

  task automatic test_single_err;
    run_sweep(16'h6996, 16'h6997, 8'd2, -1);
    tests++;
    if (res !== model(16'h6996, 16'h6997) || bus.err_cnt !== 5'd1 || bus.first_err_idx !== 4'd0) begin
      fails++; $display("FAIL single_err_result: got %0h want %0h", res, model(16'h6996, 16'h6997));
    end
    tests++;
    if (done_k !== 48) begin fails++; $display("FAIL single_err_done: got %0d want 48", done_k); end
  endtask

  task automatic test_all_err;
    run_sweep(16'h6996, 16'h9669, 8'd0, -1);
    tests++;
    if (done_k !== 32) begin fails++; $display("FAIL hold0_done_cycle: got %0d want 32", done_k); end
    tests++;
    if (vec_bad !== 0) begin fails++; $display("FAIL hold0_vectors: got %0d bad cycles want 0", vec_bad); end
    tests++;
    if (res !== model(16'h6996, 16'h9669) || bus.err_cnt !== 5'd16) begin
      fails++; $display("FAIL all_err_result: got %0h want %0h", res, model(16'h6996, 16'h9669));
    end
  endtask

  task automatic test_restart_ignored;
    run_sweep(16'h6996, 16'h6996, 8'd2, 22);
    tests++;
    if (done_k !== 48 || done_cnt !== 1) begin
      fails++; $display("FAIL restart_timing: got done at %0d (%0d pulses) want 48 (1)", done_k, done_cnt);
    end
    tests++;
    if (res !== model(16'h6996, 16'h6996)) begin
      fails++; $display("FAIL restart_result: got %0h want %0h", res, model(16'h6996, 16'h6996));
    end
  endtask

  task automatic test_vec_seq;
    logic [15:0] ft, ex;
    ft = 16'($urandom);
    ex = 16'($urandom);
    run_sweep(ft, ex, 8'd3, -1);
    tests++;
    if (vec_bad !== 0 || busy_bad !== 0) begin
      fails++; $display("FAIL seq_hold3: got %0d/%0d bad cycles want 0", vec_bad, busy_bad);
    end
    tests++;
    if (done_k !== 64) begin fails++; $display("FAIL seq_done_cycle: got %0d want 64", done_k); end
    tests++;
    if (res !== model(ft, ex)) begin fails++; $display("FAIL seq_result: got %0h want %0h", res, model(ft, ex)); end
  endtask

  task automatic test_random;
    logic [15:0] ft, ex;
    logic [7:0]  hl;
    int          exp_k;
    for (int n = 0; n < 6; n++) begin
      ft = 16'($urandom);
      ex = ($urandom_range(0, 2) == 0) ? ft : 16'($urandom);
      hl = 8'($urandom_range(0, 6));
      exp_k = 16 * (((hl == 8'd0) ? 1 : int'(hl)) + 1);
      run_sweep(ft, ex, hl, -1);
      tests++;
      if (done_k !== exp_k || vec_bad !== 0) begin
        fails++; $display("FAIL rand_timing[%0d]: got done %0d bad %0d want done %0d bad 0", n, done_k, vec_bad, exp_k);
      end
      tests++;
      if (res !== model(ft, ex)) begin fails++; $display("FAIL rand_result[%0d]: got %0h want %0h", n, res, model(ft, ex)); end
    end
  endtask

  task automatic test_abort;
    int dones, busies;
    start_sweep(16'h6996, 16'h0000, 8'd2);
    repeat (17) @(negedge clk);
    tests++;
    if (vec !== 4'd5) begin fails++; $display("FAIL abort_pre_vec: got %0d want 5", vec); end
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    @(negedge clk);
    tests++;
    if ({vec, bus.busy, bus.done, bus.pass} !== 7'd0) begin
      fails++; $display("FAIL abort_outputs: got %0h want 0", {vec, bus.busy, bus.done, bus.pass});
    end
    tests++;
    if (res !== model(16'h6996 & 16'h001F, 16'h0000)) begin
      fails++; $display("FAIL abort_partial: got %0h want %0h", res, model(16'h6996 & 16'h001F, 16'h0000));
    end
    dones = 0;
    busies = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      if (bus.busy === 1'b1) busies++;
    end
    tests++;
    if (dones !== 0 || busies !== 0) begin fails++; $display("FAIL abort_quiet: got %0d done %0d busy cycles want 0", dones, busies); end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.tt !== 16'h0016) begin
      fails++; $display("FAIL abort_beats_start: got busy %0b tt %0h want busy 0 tt 16", bus.busy, bus.tt);
    end
  endtask

  task automatic test_reset_mid;
    start_sweep(16'h6996, 16'h6996, 8'd2);
    repeat (28) @(negedge clk);
    tests++;
    if (vec !== 4'd9) begin fails++; $display("FAIL rst_mid_pre_vec: got %0d want 9", vec); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({vec, bus.busy, bus.done, res} !== 33'd0) begin
      fails++; $display("FAIL rst_mid_outputs: got %0h want 0", {vec, bus.busy, bus.done, res});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(16'h6996, 16'h6996, 8'd2, -1);
    tests++;
    if (done_k !== 48 || vec_bad !== 0 || res !== model(16'h6996, 16'h6996)) begin
      fails++; $display("FAIL rst_mid_resweep: got done %0d bad %0d res %0h want 48 0 %0h", done_k, vec_bad, res, model(16'h6996, 16'h6996));
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.hold_len = 8'd0;
    bus.exp_tt = 16'd0;
    ftab = 16'd0;
    test_reset;
    test_xor_pass;
    test_single_err;
    test_all_err;
    test_restart_ignored;
    test_vec_seq;
    test_random;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
